// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM states, flags.
// ALU_DIV_EN adds the DIVIDE state used by the iterative divider.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_SUB   = 4'd0,
    OP_SEQ   = 4'd1,
    OP_XOR   = 4'd2,
    OP_OR    = 4'd3,
    OP_ROR   = 4'd4,
    OP_DIV   = 4'd5,
    OP_NOR   = 4'd6,
    OP_SGT   = 4'd7,
    OP_MAX   = 4'd8,
    OP_PASSB = 4'd9,
    OP_SRL   = 4'd10,
    OP_ADD   = 4'd11
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
`ifdef ALU_DIV_EN
    S_DIVIDE = 2'd1,
`endif
    S_DONE   = 2'd2
  } alu_state_e;

  typedef struct packed {
    logic carry;
    logic zero;
    logic overflow;
    logic sign;
  } alu_flags_t;

endpackage

// File: rtl/alu_seq_if.sv
// Issue/writeback handshake bundle for alu_seq_core.
// master = issuing side, slave = the ALU.
interface alu_seq_if #(
  parameter int WIDTH = 64
);
  localparam int SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] input1;
  logic [WIDTH-1:0] input2;
  logic [SHW-1:0]   shiftValue;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carryFlag;
  logic             zeroFlag;
  logic             overFlowFlag;
  logic             signFlag;

  modport master (
    output in_valid, opcode, input1, input2,
    output shiftValue, out_ready,
    input  in_ready, out_valid, result,
    input  carryFlag, zeroFlag,
    input  overFlowFlag, signFlag
  );

  modport slave (
    input  in_valid, opcode, input1, input2,
    input  shiftValue, out_ready,
    output in_ready, out_valid, result,
    output carryFlag, zeroFlag,
    output overFlowFlag, signFlag
  );

endinterface

// File: rtl/alu_seq_divider.sv
// Radix-2 restoring unsigned divider, one quotient bit per cycle.
// Only instantiated when ALU_DIV_EN is defined.
module alu_seq_divider #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic             dz
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] rem, quo, dvs;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem_sh, trial;
  logic             fits;

  // dividend bits shift out of quo's MSB as quotient bits enter its LSB
  assign rem_sh = {rem, quo[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, dvs};
  assign fits   = ~trial[WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem  <= '0;
      quo  <= '0;
      dvs  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      dz   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem  <= '0;
        quo  <= dividend;
        dvs  <= divisor;
        dz   <= (divisor == '0);
        cnt  <= CW'(WIDTH);
        busy <= 1'b1;
      end else if (busy) begin
        rem <= fits ? trial[WIDTH-1:0]
                    : rem_sh[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], fits};
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign quotient = quo;

endmodule

// File: rtl/alu_seq_core.sv
// Registered 12-op ALU with valid/ready on both sides.
// Define ALU_DIV_EN to build the iterative divider for DIV.
module alu_seq_core #(
  parameter int WIDTH = 64
) (
  input  logic     clk,
  input  logic     rst,
  alu_seq_if.slave bus
);
  import alu_seq_pkg::*;

  logic [1:0] rst_q;
  logic       rst_i;

  // async assert, release aligned to clk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_q <= 2'b11;
    else     rst_q <= {rst_q[0], 1'b0};
  end
  assign rst_i = rst_q[1];

  alu_op_e          op;
  alu_state_e       state, state_n, nxt;
  logic [WIDTH-1:0] a, b, rot, alu_r, res_q;
  logic [WIDTH:0]   sum, dif;
  alu_flags_t       alu_f, flg_q;
  logic             rdy, accept, is_div;

  assign op  = alu_op_e'(bus.opcode);
  assign a   = bus.input1;
  assign b   = bus.input2;
  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} - {1'b0, b};
  assign rot = WIDTH'({a, a} >> bus.shiftValue);

  always_comb begin
    alu_r = '0;
    alu_f = '0;
    case (op)
      OP_ADD: begin
        alu_r          = sum[WIDTH-1:0];
        alu_f.carry    = sum[WIDTH];
        alu_f.overflow = (a[WIDTH-1] == b[WIDTH-1])
                      && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_r          = dif[WIDTH-1:0];
        alu_f.carry    = dif[WIDTH];
        alu_f.overflow = (a[WIDTH-1] != b[WIDTH-1])
                      && (dif[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SEQ:   alu_r = WIDTH'(a == b);
      OP_SGT:   alu_r = WIDTH'($signed(a) > $signed(b));
      OP_XOR:   alu_r = a ^ b;
      OP_OR:    alu_r = a | b;
      OP_NOR:   alu_r = ~(a | b);
      OP_ROR:   alu_r = rot;
      OP_MAX:   alu_r = (a > b) ? a : b;
      OP_PASSB: alu_r = b;
      OP_SRL:   alu_r = a >> bus.shiftValue;
`ifndef ALU_DIV_EN
      OP_DIV:   alu_f.overflow = 1'b1;
`endif
      default: ;
    endcase
    alu_f.zero = (alu_r == '0);
    alu_f.sign = alu_r[WIDTH-1];
  end

`ifdef ALU_DIV_EN
  logic             div_busy, div_done, div_dz;
  logic [WIDTH-1:0] div_q;

  alu_seq_divider #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .rst      (rst_i),
    .start    (accept & is_div),
    .dividend (a),
    .divisor  (b),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_q),
    .dz       (div_dz)
  );

  assign is_div = (op == OP_DIV);
  assign nxt    = is_div ? S_DIVIDE : S_DONE;
`else
  assign is_div = 1'b0;
  assign nxt    = S_DONE;
`endif

  always_comb begin
    state_n = state;
    rdy     = 1'b0;
    case (state)
      S_IDLE:  rdy = 1'b1;
      S_DONE:  rdy = bus.out_ready;
      default: rdy = 1'b0;
    endcase
    rdy    = rdy & ~rst_i;
    accept = bus.in_valid & rdy;
    case (state)
      S_IDLE: if (accept) state_n = nxt;
`ifdef ALU_DIV_EN
      S_DIVIDE:
        if (div_done & ~div_busy) state_n = S_DONE;
`endif
      S_DONE:
        if (bus.out_ready)
          state_n = accept ? nxt : S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state <= S_IDLE;
      res_q <= '0;
      flg_q <= '0;
    end else begin
      state <= state_n;
      if (accept & ~is_div) begin
        res_q <= alu_r;
        flg_q <= alu_f;
      end
`ifdef ALU_DIV_EN
      else if (state == S_DIVIDE && div_done) begin
        res_q          <= div_dz ? '0 : div_q;
        flg_q.carry    <= 1'b0;
        flg_q.zero     <= div_dz | (div_q == '0);
        flg_q.overflow <= div_dz;
        flg_q.sign     <= ~div_dz & div_q[WIDTH-1];
      end
`endif
    end
  end

  assign bus.in_ready     = rdy;
  assign bus.out_valid    = (state == S_DONE);
  assign bus.result       = res_q;
  assign bus.carryFlag    = flg_q.carry;
  assign bus.zeroFlag     = flg_q.zero;
  assign bus.overFlowFlag = flg_q.overflow;
  assign bus.signFlag     = flg_q.sign;

endmodule
